// File: rtl/replay_pkg.sv
// rtl/replay_pkg.sv - shared state type and default parameters for replay_control
package replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int REPLAY_ADDR_WIDTH       = 5;
  localparam int REPLAY_NUM_BANKS        = 2;
  localparam int REPLAY_CNT_WIDTH        = 8;
  localparam int REPLAY_RESTART_ON_ERROR = 1;

endpackage

// File: rtl/replay_control_lowest_bit_sel.sv
// rtl/replay_control_lowest_bit_sel.sv - lowest-set-bit priority encoder with valid flag
module lowest_bit_sel #(
  parameter int WIDTH = 2,
  parameter int IDX_W = 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/replay_control.sv
// rtl/replay_control.sv - sweeps every register address of each errored bank, then pulses done
module replay_control
  import replay_pkg::*;
#(
  parameter int ADDR_WIDTH       = REPLAY_ADDR_WIDTH,
  parameter int NUM_BANKS        = REPLAY_NUM_BANKS,
  parameter int CNT_WIDTH        = REPLAY_CNT_WIDTH,
  parameter int RESTART_ON_ERROR = REPLAY_RESTART_ON_ERROR,
  localparam int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BANKS-1:0]  error_i,
  input  logic                  replay_ready_i,
  output logic                  fetch_block_o,
  output logic                  replay_valid_o,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic [BANK_W-1:0]     replay_bank_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  state_e                state_q, state_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  any_err, hit_cur;
  logic [NUM_BANKS-1:0]  cur_onehot, mask_clr, sel_in;
  logic [BANK_W-1:0]     sel_idx;
  logic                  sel_valid;

  // One encoder serves both the initial load and the end-of-bank reselect.
  always_comb begin
    any_err    = |error_i;
    cur_onehot = NUM_BANKS'(1) << bank_q;
    hit_cur    = (RESTART_ON_ERROR != 0) && ((error_i & cur_onehot) != '0);
    mask_clr   = (mask_q & ~cur_onehot) | error_i;
    sel_in     = (state_q == ST_REPLAY) ? mask_clr : error_i;
  end

  lowest_bit_sel #(
    .WIDTH (NUM_BANKS),
    .IDX_W (BANK_W)
  ) u_sel (
    .in_i    (sel_in),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    cnt_d   = (any_err && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        mask_d  = '0;
        addr_d  = '0;
        bank_d  = '0;
        if (any_err) begin
          state_d = ST_REPLAY;
          mask_d  = error_i;
          bank_d  = sel_idx;
        end
      end
      ST_REPLAY: begin
        mask_d = mask_q | error_i;
        if (hit_cur) begin
          addr_d = '0;
        end else if (replay_ready_i) begin
          if (addr_q == ADDR_MAX) begin
            // Re-errors of the current bank survive the clear when restart is off.
            mask_d = mask_clr;
            addr_d = '0;
            if (!sel_valid) begin
              state_d = ST_DONE;
              bank_d  = '0;
            end else begin
              bank_d  = sel_idx;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
        addr_d  = '0;
        bank_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    replay_valid_o = (state_q == ST_REPLAY);
    replay_addr_o  = replay_valid_o ? addr_q : '0;
    replay_bank_o  = replay_valid_o ? bank_q : '0;
    done_o         = (state_q == ST_DONE);
    fetch_block_o  = (state_q != ST_IDLE);
    err_count_o    = cnt_q;
  end

endmodule
